// File: rtl/ahb_extmem_sram_pkg.sv
// Shared definitions for the EXT_MEM AHB-Lite to asynchronous 16-bit SRAM bridge.
// Holds the HTRANS encodings, the word size limit and the controller state type.
package ahb_extmem_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_LO,
    S_ACC_HI,
    S_RESP,
    S_ERR1,
    S_ERR2
  } state_t;

  // SEQ and NONSEQ both start a transfer; bursts are handled beat by beat.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_extmem_sram_half_port.sv
// One 16-bit access to the asynchronous SRAM: counter and strobe timing.
// The access runs while start is held; done marks its final (recovery/latch) cycle.
module sram_half_port #(
  parameter int SRAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  strb,
  input  logic [15:0] wdata,
  output logic        done,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        ub_n,
  output logic        lb_n,
  output logic        dq_oe,
  output logic [15:0] dq_o
);

  localparam logic [3:0] LAST = 4'(SRAM_WAIT + 1);

  logic [3:0] cnt_q, cnt_d;

  // Counter restarts at every half boundary so back-to-back halves each get full timing.
  always_comb begin
    cnt_d = cnt_q + 4'd1;
    if (!start || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    done  = start && (cnt_q == LAST);
    ce_n  = !start;
    oe_n  = !(start && !write);
    // WE_N rises one cycle before the address moves to give data/address hold time.
    we_n  = !(start && write && (cnt_q != LAST));
    ub_n  = !start || (write && !strb[1]);
    lb_n  = !start || (write && !strb[0]);
    dq_oe = start && write;
    dq_o  = dq_oe ? wdata : 16'h0000;
  end

endmodule

// File: rtl/ahb_extmem_sram.sv
// AHB-Lite subordinate for the EXT_MEM window: each 32-bit beat becomes one or two
// halfword accesses to the board's asynchronous 1M x 16 SRAM.
module ahb_extmem_sram
  import ahb_extmem_sram_pkg::*;
#(
  parameter int AHBW      = 32,
  parameter int SRAM_AW   = 20,
  parameter int SRAM_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSELExt,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic [15:0]          SRAM_DQ_O,
  input  logic [15:0]          SRAM_DQ_I,
  output logic                 SRAM_DQ_OE,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N
);

  state_t               state_q, state_d;
  state_t               cap_state;
  logic [SRAM_AW-2:0]   addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 need_hi_q, need_hi_d;
  logic [AHBW-1:0]      hrdata_q, hrdata_d;
  logic                 capture;
  logic                 acc;
  logic                 half;
  logic                 hp_done;
  logic [1:0]           hp_strb;
  logic [15:0]          hp_wdata;
  logic                 unused_bits;

  // Burst type, word-aligned byte offset and out-of-window address bits carry no information here.
  assign unused_bits = ^{HADDR[31:SRAM_AW+1], HADDR[0], HBURST};

  always_comb begin
    capture = HSELExt && htrans_active(HTRANS) && HREADY &&
              (state_q == S_IDLE || state_q == S_RESP);

    cap_state = S_ACC_LO;
    if (HSIZE > HSIZE_WORD) begin
      cap_state = S_ERR1;
    end else if (HSIZE != HSIZE_WORD && HADDR[1]) begin
      cap_state = S_ACC_HI;
    end

    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    need_hi_d = need_hi_q;
    hrdata_d  = hrdata_q;

    case (state_q)
      S_IDLE: begin
        if (capture) state_d = cap_state;
      end
      S_ACC_LO: begin
        if (hp_done) begin
          state_d = need_hi_q ? S_ACC_HI : S_RESP;
          if (!write_q) hrdata_d[15:0] = SRAM_DQ_I;
        end
      end
      S_ACC_HI: begin
        if (hp_done) begin
          state_d = S_RESP;
          if (!write_q) hrdata_d[31:16] = SRAM_DQ_I;
        end
      end
      // A new address phase here chains straight into the next access.
      S_RESP:  state_d = capture ? cap_state : S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      addr_d    = HADDR[SRAM_AW:2];
      write_d   = HWRITE;
      need_hi_d = (HSIZE == HSIZE_WORD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      need_hi_q <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      need_hi_q <= need_hi_d;
      hrdata_q  <= hrdata_d;
    end
  end

  always_comb begin
    acc      = (state_q == S_ACC_LO) || (state_q == S_ACC_HI);
    half     = (state_q == S_ACC_HI);
    hp_wdata = half ? HWDATA[31:16] : HWDATA[15:0];
    hp_strb  = half ? HWSTRB[3:2]   : HWSTRB[1:0];
  end

  sram_half_port #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_half_port (
    .clk   (clk),
    .reset (reset),
    .start (acc),
    .write (write_q),
    .strb  (hp_strb),
    .wdata (hp_wdata),
    .done  (hp_done),
    .ce_n  (SRAM_CE_N),
    .oe_n  (SRAM_OE_N),
    .we_n  (SRAM_WE_N),
    .ub_n  (SRAM_UB_N),
    .lb_n  (SRAM_LB_N),
    .dq_oe (SRAM_DQ_OE),
    .dq_o  (SRAM_DQ_O)
  );

  assign SRAM_ADDR = acc ? {addr_q, half} : '0;
  assign HRDATA    = hrdata_q;
  assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_RESP) || (state_q == S_ERR2);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_extmem_sram.sv
// Bench for ahb_extmem_sram: two instances (SRAM_WAIT 0 and 3), each with its own SRAM model;
// expected read data is queued when a read is issued and checked at its response cycle.
module tb_ahb_extmem_sram;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel0 = 1'b0, sel3 = 1'b0, use3 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = '0;

  logic [31:0] hrdata0, hrdata3;
  logic        hro0, hro3, hresp0, hresp3;
  logic [19:0] a0, a3;
  logic [15:0] dqo0, dqo3, dqi0, dqi3;
  logic        oe0, oe3, ce0_n, ce3_n, oe0_n, oe3_n, we0_n, we3_n, ub0_n, ub3_n, lb0_n, lb3_n;

  ahb_extmem_sram #(.AHBW(32), .SRAM_AW(20), .SRAM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .HSELExt(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(hro0), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0),
    .SRAM_ADDR(a0), .SRAM_DQ_O(dqo0), .SRAM_DQ_I(dqi0), .SRAM_DQ_OE(oe0),
    .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n), .SRAM_WE_N(we0_n), .SRAM_UB_N(ub0_n),
    .SRAM_LB_N(lb0_n)
  );

  ahb_extmem_sram #(.AHBW(32), .SRAM_AW(20), .SRAM_WAIT(3)) u_dut3 (
    .clk(clk), .reset(reset), .HSELExt(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(hro3), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HRDATA(hrdata3), .HREADYOUT(hro3), .HRESP(hresp3),
    .SRAM_ADDR(a3), .SRAM_DQ_O(dqo3), .SRAM_DQ_I(dqi3), .SRAM_DQ_OE(oe3),
    .SRAM_CE_N(ce3_n), .SRAM_OE_N(oe3_n), .SRAM_WE_N(we3_n), .SRAM_UB_N(ub3_n),
    .SRAM_LB_N(lb3_n)
  );

  // SRAM models: byte-lane writes while CE_N and WE_N are low, combinational reads under OE_N.
  logic [15:0] mem0 [0:255];
  logic [15:0] mem3 [0:255];

  always @(posedge clk) begin
    if (!ce0_n && !we0_n) begin
      if (!ub0_n) mem0[a0[7:0]][15:8] <= dqo0[15:8];
      if (!lb0_n) mem0[a0[7:0]][7:0]  <= dqo0[7:0];
    end
    if (!ce3_n && !we3_n) begin
      if (!ub3_n) mem3[a3[7:0]][15:8] <= dqo3[15:8];
      if (!lb3_n) mem3[a3[7:0]][7:0]  <= dqo3[7:0];
    end
  end

  assign dqi0 = (!ce0_n && !oe0_n) ? mem0[a0[7:0]] : 16'h0000;
  assign dqi3 = (!ce3_n && !oe3_n) ? mem3[a3[7:0]] : 16'h0000;

  logic        hrdy, hresp;
  logic [31:0] hrdata;
  assign hrdy   = use3 ? hro3   : hro0;
  assign hresp  = use3 ? hresp3 : hresp0;
  assign hrdata = use3 ? hrdata3 : hrdata0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle strobe activity counters, sampled mid-cycle.
  int m_ce = 0, m_hi = 0, m_ub = 0, m_lb = 0, m_we = 0, m_oe = 0, m_conf = 0;
  int m3_ce = 0, m3_lo = 0, m3_we = 0, m3_oe = 0, m3_conf = 0;
  always @(negedge clk) begin
    if (!ce0_n) m_ce <= m_ce + 1;
    if (!ce0_n && a0[0]) m_hi <= m_hi + 1;
    if (!ce0_n && !ub0_n) m_ub <= m_ub + 1;
    if (!ce0_n && !lb0_n) m_lb <= m_lb + 1;
    if (!we0_n) m_we <= m_we + 1;
    if (!oe0_n) m_oe <= m_oe + 1;
    if (oe0 && !oe0_n) m_conf <= m_conf + 1;
    if (!ce3_n) m3_ce <= m3_ce + 1;
    if (!ce3_n && !a3[0]) m3_lo <= m3_lo + 1;
    if (!we3_n) m3_we <= m3_we + 1;
    if (!oe3_n) m3_oe <= m3_oe + 1;
    if (oe3 && !oe3_n) m3_conf <= m3_conf + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] tr);
    if (use3) sel3 = 1'b1; else sel0 = 1'b1;
    haddr  = addr;
    htrans = tr;
    hwrite = wr;
    hsize  = size;
  endtask

  task automatic data_phase(input logic [31:0] wd, input logic [3:0] st);
    sel0   = 1'b0;
    sel3   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    hwstrb = st;
  endtask

  task automatic wait_ready(output int waits);
    waits = 0;
    while (!hrdy && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 64) chk("ready_timeout", 32'(waits), 32'd0);
  endtask

  task automatic check_resp(input bit wr);
    logic [31:0] e;
    chk("hresp_ok", 32'(hresp), 32'd0);
    if (!wr) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", hrdata, e);
      end
    end
  endtask

  // One complete beat: address phase, data phase, wait states, response check.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input logic [3:0] st, output int waits);
    @(negedge clk);
    addr_phase(wr, addr, size, 2'b10);
    @(negedge clk);
    data_phase(wd, st);
    wait_ready(waits);
    check_resp(wr);
  endtask

  int w, w2, r1, r2;
  int s_ce, s_hi, s_ub, s_lb, s_we, s_oe, s_lo;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hreadyout", 32'(hro0), 32'd1);
    chk("rst_hresp", 32'(hresp0), 32'd0);
    chk("rst_hrdata", hrdata0, 32'd0);
    chk("rst_strobes", {27'd0, ce0_n, oe0_n, we0_n, ub0_n, lb0_n}, 32'h1F);
    chk("rst_addr_dq", {11'd0, oe0, a0}, 32'd0);
    chk("rst_dqo", 32'(dqo0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word write then read back, no extra wait states.
    s_we = m_we;
    xfer(1'b1, 32'h0200_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, w);
    chk("wr_word_waits", 32'(w), 32'd4);
    chk("wr_word_lo", 32'(mem0[8'h08]), 32'h0000_BEEF);
    chk("wr_word_hi", 32'(mem0[8'h09]), 32'h0000_DEAD);
    chk("wr_word_we_cycles", 32'(m_we - s_we), 32'd2);
    exp_q.push_back(32'hDEAD_BEEF);
    xfer(1'b0, 32'h0200_0010, 3'd2, 32'h0, 4'h0, w);
    chk("rd_word_waits", 32'(w), 32'd4);

    // Byte write into the top byte: only the HI half runs, upper lane only.
    s_ce = m_ce; s_hi = m_hi; s_ub = m_ub; s_lb = m_lb;
    xfer(1'b1, 32'h0200_0013, 3'd0, 32'h5A00_0000, 4'h8, w);
    chk("byte_waits", 32'(w), 32'd2);
    chk("byte_ce_cycles", 32'(m_ce - s_ce), 32'd2);
    chk("byte_hi_cycles", 32'(m_hi - s_hi), 32'd2);
    chk("byte_ub_cycles", 32'(m_ub - s_ub), 32'd2);
    chk("byte_lb_cycles", 32'(m_lb - s_lb), 32'd0);
    exp_q.push_back(32'h5AAD_BEEF);
    xfer(1'b0, 32'h0200_0010, 3'd2, 32'h0, 4'h0, w);

    // Write with no strobes set: same timing, memory untouched.
    xfer(1'b1, 32'h0200_0010, 3'd2, 32'h0123_4567, 4'h0, w);
    chk("nostrb_waits", 32'(w), 32'd4);
    chk("nostrb_mem", {mem0[8'h09], mem0[8'h08]}, 32'h5AAD_BEEF);

    // Back-to-back reads with the second address phase in the first RESP cycle.
    xfer(1'b1, 32'h0200_0000, 3'd2, 32'h2222_1111, 4'hF, w);
    xfer(1'b1, 32'h0200_0004, 3'd2, 32'h4444_3333, 4'hF, w);
    exp_q.push_back(32'h2222_1111);
    exp_q.push_back(32'h4444_3333);
    @(negedge clk);
    addr_phase(1'b0, 32'h0200_0000, 3'd2, 2'b10);
    @(negedge clk);
    data_phase(32'h0, 4'h0);
    wait_ready(w);
    r1 = cyc;
    check_resp(1'b0);
    addr_phase(1'b0, 32'h0200_0004, 3'd2, 2'b11);
    @(negedge clk);
    data_phase(32'h0, 4'h0);
    wait_ready(w2);
    r2 = cyc;
    check_resp(1'b0);
    chk("b2b_waits", 32'(w2), 32'd4);
    chk("b2b_resp_gap", 32'(r2 - r1), 32'd5);

    // Oversized transfer takes the two-cycle error response with no SRAM activity.
    s_ce = m_ce;
    @(negedge clk);
    addr_phase(1'b0, 32'h0200_0000, 3'd3, 2'b10);
    @(negedge clk);
    data_phase(32'h0, 4'h0);
    chk("err1", {30'd0, hro0, hresp0}, 32'b01);
    @(negedge clk);
    chk("err2", {30'd0, hro0, hresp0}, 32'b11);
    @(negedge clk);
    chk("err_idle", {30'd0, hro0, hresp0}, 32'b10);
    chk("err_no_ce", 32'(m_ce - s_ce), 32'd0);

    // SRAM_WAIT=3 instance: five cycles per half.
    use3 = 1'b1;
    s_we = m3_we;
    xfer(1'b1, 32'h0200_0010, 3'd2, 32'hF00D_CAFE, 4'hF, w);
    chk("w3_wr_waits", 32'(w), 32'd10);
    chk("w3_wr_we_cycles", 32'(m3_we - s_we), 32'd8);
    s_ce = m3_ce; s_lo = m3_lo; s_we = m3_we; s_oe = m3_oe;
    exp_q.push_back(32'hF00D_CAFE);
    xfer(1'b0, 32'h0200_0010, 3'd2, 32'h0, 4'h0, w);
    chk("w3_rd_waits", 32'(w), 32'd10);
    chk("w3_rd_ce_cycles", 32'(m3_ce - s_ce), 32'd10);
    chk("w3_rd_lo_cycles", 32'(m3_lo - s_lo), 32'd5);
    chk("w3_rd_oe_cycles", 32'(m3_oe - s_oe), 32'd10);
    chk("w3_rd_we_cycles", 32'(m3_we - s_we), 32'd0);
    use3 = 1'b0;

    // Reset asserted in the HI half of a word write.
    @(negedge clk);
    addr_phase(1'b1, 32'h0200_0020, 3'd2, 2'b10);
    @(negedge clk);
    data_phase(32'h1234_5678, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_hi", {30'd0, ce0_n, a0[0]}, 32'b01);
    reset = 1'b1;
    #1;
    chk("midrst_strobes", {27'd0, ce0_n, oe0_n, we0_n, ub0_n, lb0_n}, 32'h1F);
    chk("midrst_dq_oe", 32'(oe0), 32'd0);
    chk("midrst_hreadyout", 32'(hro0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("postrst_idle", {30'd0, hro0, ce0_n}, 32'b11);
    exp_q.push_back(32'h5AAD_BEEF);
    xfer(1'b0, 32'h0200_0010, 3'd2, 32'h0, 4'h0, w);
    chk("postrst_rd_waits", 32'(w), 32'd4);

    @(negedge clk);
    chk("oe_dq_conflict0", 32'(m_conf), 32'd0);
    chk("oe_dq_conflict3", 32'(m3_conf), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
